acq_ctrl: RTL
=============

// Module: acq_ctrl
// PURPOSE
//  Acquisition controller. Stimulus side drives arm, trigger and sample strobes; this block
//  sequences one acquisition of N samples into an internal buffer. It then plays the samples
//  back over a valid/ready readout port.
//  Sits between the sample front-end and the downstream logger/VCD-dumped bench.
// PARAMETERS
//  DATA_W   16                    sample width in bits
//  DEPTH    64                    buffer depth in samples (power of 2, >=2)
//  CNT_W    $clog2(DEPTH+1)       width of sample counts (derived, do not override)
// PORTS
//  clk            in   1       single clock, all logic on rising edge
//  rst_n          in   1       asynchronous reset, active low
//  arm_i          in   1       start request; sampled only in IDLE
//  abort_i        in   1       cancel; acts in any state
//  trig_i         in   1       trigger; sampled only in ARMED
//  num_samples_i  in   CNT_W   samples per acquisition; latched on accepted arm
//  smp_valid_i    in   1       sample strobe
//  smp_data_i     in   DATA_W  sample value
//  rd_data_o      out  DATA_W  readout data
//  rd_valid_o     out  1       readout data valid
//  rd_ready_i     in   1       readout sink ready
//  busy_o         out  1       1 in every state except IDLE
//  done_o         out  1       1-cycle pulse when the last readout beat is accepted
//  overrun_o      out  1       sticky: a sample arrived while the block could not store it
//  state_o        out  2       current state encoding (acq_state_e)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state IDLE; all outputs 0; pointers, counters and latched N = 0.
//    Buffer contents are don't-care.
//  - IDLE:
//      arm_i=1 -> ARMED next edge. Latches N = num_samples_i. N=0 or N>DEPTH becomes N=DEPTH.
//      The same edge clears overrun_o.
//  - ARMED:
//      trig_i=1 -> ACQUIRE. If smp_valid_i=1 in the trigger cycle, that sample is written as
//      sample 0. smp_valid_i before the trigger is ignored and does not set overrun.
//  - ACQUIRE:
//      Each smp_valid_i=1 writes smp_data_i at wr_ptr and increments wr_ptr.
//      When the write count reaches N, the next state is READOUT; no write occurs past N.
//  - READOUT:
//      rd_ptr starts at 0. Buffer read is synchronous, 1 cycle.
//      rd_valid_o rises 2 edges after the edge that wrote the final sample.
//      rd_data_o and rd_valid_o are held stable while rd_valid_o=1 and rd_ready_i=0.
//      A beat transfers when rd_valid_o and rd_ready_i are both 1. Back-to-back beats are
//      allowed, 1 beat/cycle at full throughput.
//      After beat N-1 transfers: done_o=1 for exactly 1 cycle, rd_valid_o=0, state IDLE,
//      all on the same edge.
//      smp_valid_i=1 in READOUT drops the sample and sets overrun_o (sticky).
//  - abort_i=1 in any state -> IDLE next edge. rd_valid_o drops, no done_o, overrun_o keeps
//    its value. abort_i has priority over arm_i, trig_i and a final-beat transfer in the
//    same cycle.
//  - arm_i outside IDLE and trig_i outside ARMED are ignored.
//  - Pointers are CNT_W-1 bits wide; since N<=DEPTH they never wrap within one acquisition.
//  - Re-arming after done_o: the new acquisition overwrites the buffer from address 0.
// STRUCTURE
//  - Package acq_pkg:
//      typedef enum logic [1:0] {ACQ_IDLE=0, ACQ_ARMED=1, ACQ_ACQUIRE=2, ACQ_READOUT=3}
//        acq_state_e
//      default DATA_W and DEPTH localparams.
//  - Sub-module acq_buf: simple dual-port RAM, DEPTH x DATA_W.
//      One write port; one synchronous read port with read-enable, so rd_data_o can be held
//      under backpressure.
//  - acq_ctrl holds the FSM, counters, N latch, the overrun flag and the readout skid logic.
// TESTING
//  1 Basic run. Reset; N=4; arm; trig; 4 samples 0x11..0x14 with rd_ready_i=1.
//    -> readout 0x11,0x12,0x13,0x14 in order. done_o is a single 1-cycle pulse. busy_o
//       returns to 0 and state_o=0.
//  2 Backpressure. N=3; toggle rd_ready_i 1,0,0,1,...
//    -> rd_data_o is stable during every stall; exactly 3 beats transfer; no beat is
//       duplicated or lost.
//  3 N clamp. num_samples_i=0, then DEPTH+5.
//    -> each run captures exactly DEPTH samples and reads out DEPTH beats.
//  4 Overrun and trigger edge cases.
//    - 5 extra strobes during READOUT -> overrun_o=1, readout data unchanged; the next arm
//      clears overrun_o.
//    - Strobes in ARMED before trig -> ignored.
//    - Sample in the trigger cycle -> captured as sample 0.
//  5 Abort.
//    - abort_i mid-ACQUIRE (2 of 8 written) -> IDLE next cycle, no rd_valid_o, no done_o.
//    - abort_i coincident with the final readout beat -> no done_o.
//    - arm_i+abort_i together in IDLE -> stays IDLE.
//  6 Async reset mid-READOUT. Pull rst_n low between edges.
//    -> all outputs 0 immediately, without waiting for clk; a fresh run afterwards passes
//       scenario 1.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types and defaults for the acquisition controller slice.
// State encoding is visible on state_o, so the values are fixed.
package acq_pkg;

  typedef enum logic [1:0] {
    ACQ_IDLE    = 2'd0,
    ACQ_ARMED   = 2'd1,
    ACQ_ACQUIRE = 2'd2,
    ACQ_READOUT = 2'd3
  } acq_state_e;

  localparam int ACQ_DATA_W = 16;
  localparam int ACQ_DEPTH  = 64;

endpackage

// File: rtl/acq_buf.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// The read register only updates on rdEn, so the last word is held under backpressure.
module acq_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/acq_ctrl.sv
// Acquisition controller: arm, trigger, capture N samples into acq_buf, then
// play them back over a valid/ready port through a two-stage read pipeline.
module acq_ctrl
  import acq_pkg::*;
#(
  parameter int DATA_W = ACQ_DATA_W,
  parameter int DEPTH  = ACQ_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              trig_i,
  input  logic [CNT_W-1:0]  num_samples_i,
  input  logic              smp_valid_i,
  input  logic [DATA_W-1:0] smp_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  output logic [1:0]        state_o
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  acq_state_e stateReg, stateNext;

  logic [CNT_W-1:0]  nReg;
  logic [CNT_W-1:0]  wrCntReg;
  logic [CNT_W-1:0]  rdCntReg;
  logic [CNT_W-1:0]  beatCntReg;
  logic              ramValidReg;
  logic              rdValidReg;
  logic [DATA_W-1:0] rdDataReg;
  logic              doneReg;
  logic              overrunReg;

  logic [CNT_W-1:0]  nClamped;
  logic [DATA_W-1:0] ramDout;
  logic              inReadout;
  logic              armAccept;
  logic              wrEn;
  logic              acqComplete;
  logic              ramEn;
  logic              loadOut;
  logic              fire;
  logic              lastBeat;

  always_comb begin
    nClamped = num_samples_i;
    if (num_samples_i == '0 || num_samples_i > DEPTH_C) begin
      nClamped = DEPTH_C;
    end
  end

  assign inReadout = (stateReg == ACQ_READOUT);
  assign armAccept = (stateReg == ACQ_IDLE) && arm_i && !abort_i;

  // A sample in the trigger cycle is sample 0; strobes before the trigger never write.
  assign wrEn = !abort_i && smp_valid_i &&
                (((stateReg == ACQ_ARMED) && trig_i) ||
                 ((stateReg == ACQ_ACQUIRE) && (wrCntReg != nReg)));
  assign acqComplete = wrEn && ((wrCntReg + ONE_C) == nReg);

  // Read pipeline: RAM output register (stage 1) feeds the output register (stage 2).
  // Stage 2 loads whenever it is empty or being drained; stage 1 refills behind it.
  assign fire     = inReadout && rdValidReg && rd_ready_i;
  assign lastBeat = fire && (beatCntReg == (nReg - ONE_C));
  assign loadOut  = inReadout && ramValidReg && (!rdValidReg || rd_ready_i);
  assign ramEn    = inReadout && !abort_i && (rdCntReg != nReg) &&
                    (!ramValidReg || loadOut);

  always_comb begin
    stateNext = stateReg;
    if (abort_i) begin
      stateNext = ACQ_IDLE;
    end else begin
      case (stateReg)
        ACQ_IDLE: begin
          if (arm_i) stateNext = ACQ_ARMED;
        end
        ACQ_ARMED: begin
          if (trig_i) stateNext = acqComplete ? ACQ_READOUT : ACQ_ACQUIRE;
        end
        ACQ_ACQUIRE: begin
          if (acqComplete) stateNext = ACQ_READOUT;
        end
        ACQ_READOUT: begin
          if (lastBeat) stateNext = ACQ_IDLE;
        end
        default: stateNext = ACQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= ACQ_IDLE;
      doneReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      doneReg  <= lastBeat && !abort_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nReg       <= '0;
      wrCntReg   <= '0;
      overrunReg <= 1'b0;
    end else begin
      if (armAccept) begin
        nReg       <= nClamped;
        wrCntReg   <= '0;
        overrunReg <= 1'b0;
      end else if (wrEn) begin
        wrCntReg <= wrCntReg + ONE_C;
      end
      if (inReadout && smp_valid_i) begin
        overrunReg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdCntReg    <= '0;
      beatCntReg  <= '0;
      ramValidReg <= 1'b0;
      rdValidReg  <= 1'b0;
      rdDataReg   <= '0;
    end else if (!inReadout || abort_i || lastBeat) begin
      rdCntReg    <= '0;
      beatCntReg  <= '0;
      ramValidReg <= 1'b0;
      rdValidReg  <= 1'b0;
    end else begin
      if (ramEn) begin
        rdCntReg <= rdCntReg + ONE_C;
      end
      if (ramEn) begin
        ramValidReg <= 1'b1;
      end else if (loadOut) begin
        ramValidReg <= 1'b0;
      end
      if (loadOut) begin
        rdDataReg  <= ramDout;
        rdValidReg <= 1'b1;
      end else if (fire) begin
        rdValidReg <= 1'b0;
      end
      if (fire) begin
        beatCntReg <= beatCntReg + ONE_C;
      end
    end
  end

  acq_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_buf (
    .clk    (clk),
    .wrEn   (wrEn),
    .wrAddr (wrCntReg[PTR_W-1:0]),
    .wrData (smp_data_i),
    .rdEn   (ramEn),
    .rdAddr (rdCntReg[PTR_W-1:0]),
    .rdData (ramDout)
  );

  assign rd_data_o  = rdDataReg;
  assign rd_valid_o = rdValidReg;
  assign busy_o     = (stateReg != ACQ_IDLE);
  assign done_o     = doneReg;
  assign overrun_o  = overrunReg;
  assign state_o    = stateReg;

endmodule
